jpeg_stream_deserializer: RTL and testbench
===========================================

Name: jpeg_stream_deserializer

Overview:
- Receiver end of the JPEG coefficient serializer.
- Accepts the serialized coefficient word stream for one frame: top_blocks_count significant blocks, each a header word followed by per-group Y/Cb/Cr DCT coefficients.
- Writes each coefficient into per-channel coefficient memories for the inverse-DCT/decode path that produces the decoded RGB frame.
- Sits between the link/stream source and the decoder's coefficient RAMs.

Parameters:
- WIDTH, 112, frame width in pixels (multiple of 8*CROP_COUNT).
- HEIGHT, 80, frame height in pixels (multiple of 8*CROP_COUNT).
- CROP_COUNT, 2, blocks per frame side; block index range 0..CROP_COUNT^2-1.
- TOP_BLOCKS_COUNT, 4, blocks carried per frame.
- DCT_DEPTH_Y, 5, Y coefficients per 8x8 group.
- DCT_DEPTH_C, 1, Cb and Cr coefficients per 8x8 group (each).
- COEF_W, 16, coefficient word width (two's complement).
- ADDR_W, 24, coefficient RAM address width.
- Derived: GPB = (WIDTH/CROP_COUNT)*(HEIGHT/CROP_COUNT)/64 (35 by default).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse; arms reception of one frame.
- in_data  in  COEF_W  stream word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word.
- y_wr_en  out  1  Y RAM write strobe.
- c_wr_en  out  1  chroma RAM write strobe.
- c_sel  out  1  0 = Cb, 1 = Cr (valid with c_wr_en).
- wr_addr  out  ADDR_W  write address.
- wr_data  out  COEF_W  coefficient.
- frame_done  out  1  one-cycle pulse: frame fully received.
- hdr_err  out  1  one-cycle pulse: bad block index.
- busy  out  1  frame reception in progress.

Behaviour:
- A word is accepted on any cycle with in_valid & in_ready. No combinational path from in_valid to in_ready; in_ready is a registered function of state only.
- States:
  - IDLE: in_ready = 0. frame_start -> HDR.
  - HDR: in_ready = 1. Accepted word[COEF_W-1:0] is the block index bi.
    - If bi >= CROP_COUNT^2: pulse hdr_err, go to IDLE, no frame_done.
    - Otherwise latch bi, clear group counter g and coefficient counter k, go to Y.
  - Y: accept DCT_DEPTH_Y words. Each word writes Y at address (bi*GPB+g)*DCT_DEPTH_Y + k. After the last, go to CB.
  - CB: accept DCT_DEPTH_C words, writing chroma with c_sel = 0 at (bi*GPB+g)*DCT_DEPTH_C + k. After the last, go to CR.
  - CR: same addressing as CB with c_sel = 1. After the last:
    - If g < GPB-1: g++, go to Y.
    - Else increment the block counter. If it is < TOP_BLOCKS_COUNT, go to HDR; otherwise go to DONE.
  - DONE: in_ready = 0. Pulse frame_done for one cycle, go to IDLE.
- Write outputs (y_wr_en, c_wr_en, c_sel, wr_addr, wr_data) are registered and appear exactly 1 cycle after acceptance. Strobes are high for one cycle per accepted coefficient. Header words produce no write.
- Stalls: in_valid low holds all counters and state. Back-to-back acceptance sustains 1 word/cycle with no bubbles, including across group and block boundaries.
- frame_start is ignored while busy. A frame_start coincident with the DONE cycle is also ignored.
- busy = 1 in HDR/Y/CB/CR/DONE, 0 in IDLE.
- Address arithmetic is unsigned. Products are computed at ADDR_W and are never truncated for legal parameters.
- Duplicate block indices within a frame are written again; later data wins. No check is made.
- A DCT_DEPTH_C of 0 is not supported.
- reset (any state, including mid-block) forces:
  - state = IDLE; all counters = 0;
  - in_ready, y_wr_en, c_wr_en, c_sel, frame_done, hdr_err, busy = 0;
  - wr_addr and wr_data = 0.
- An in-flight write registered in the same cycle as reset is dropped.
- Frame length with defaults: 4*(1+35*7) = 984 accepted words.

Test Plan:
1. Full frame, default parameters, in_valid held high:
   - Send headers 0,1,2,3 with ramp data.
   - Require exactly 700 y_wr_en and 280 c_wr_en (140 Cb, 140 Cr).
   - Require frame_done 1 cycle after the 984th word's write cycle, and in_ready low afterward.
2. Addressing, header = 3:
   - Group 0, first Y word -> wr_addr = 525. Group 0 Cb and Cr -> wr_addr = 105, with c_sel = 0 then 1.
   - Group 34, last Y word -> wr_addr = 699; its Cr -> wr_addr = 139.
3. Random in_valid gaps (~50% duty):
   - Write sequence, addresses and data are identical to scenario 1; throughput is 1 word/cycle whenever valid.
4. Bad header 4 (CROP_COUNT^2 = 4):
   - hdr_err pulses once, no writes, busy falls, frame_done stays 0.
   - A following frame_start plus a good frame completes normally.
5. Reset asserted after 100 accepted words:
   - Next cycle all outputs are 0 and state is IDLE; a fresh frame is received correctly.
   - frame_start pulsed at word 50 of an active frame has no effect.

Source files
------------

// File: rtl/jpeg_stream_deserializer.sv
// Receives one frame of the serialized JPEG coefficient stream.
// Each block is a header word carrying the block index.
// The header is followed by per-group Y, Cb and Cr DCT coefficients.
// Every coefficient is turned into a registered write strobe plus an address
// into the Y RAM or the chroma RAM.
module jpeg_stream_deserializer #(
    parameter int WIDTH            = 112,
    parameter int HEIGHT           = 80,
    parameter int CROP_COUNT       = 2,
    parameter int TOP_BLOCKS_COUNT = 4,
    parameter int DCT_DEPTH_Y      = 5,
    parameter int DCT_DEPTH_C      = 1,
    parameter int COEF_W           = 16,
    parameter int ADDR_W           = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [COEF_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              y_wr_en,
    output logic              c_wr_en,
    output logic              c_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [COEF_W-1:0] wr_data,
    output logic              frame_done,
    output logic              hdr_err,
    output logic              busy
);

    // Groups of 8x8 pixels inside one block.
    localparam int GPB  = (WIDTH / CROP_COUNT) * (HEIGHT / CROP_COUNT) / 64;
    localparam int NBLK = CROP_COUNT * CROP_COUNT;
    localparam int KMAX = (DCT_DEPTH_Y > DCT_DEPTH_C) ? DCT_DEPTH_Y : DCT_DEPTH_C;
    localparam int KW   = $clog2(KMAX + 1);
    localparam int GW   = $clog2(GPB + 1);
    localparam int BW   = $clog2(TOP_BLOCKS_COUNT + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_Y    = 3'd2;
    localparam logic [2:0] S_CB   = 3'd3;
    localparam logic [2:0] S_CR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [GW-1:0]     g_q, g_d;
    logic [BW-1:0]     blk_q, blk_d;
    logic [ADDR_W-1:0] bi_q, bi_d;

    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              y_wr_en_q, y_wr_en_d;
    logic              c_wr_en_q, c_wr_en_d;
    logic              c_sel_q, c_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [COEF_W-1:0] wr_data_q, wr_data_d;
    logic              frame_done_q, frame_done_d;
    logic              hdr_err_q, hdr_err_d;

    logic              accept;
    logic [ADDR_W-1:0] grp_idx;
    logic [ADDR_W-1:0] y_addr;
    logic [ADDR_W-1:0] c_addr;

    // Acceptance depends on the registered ready only.
    // Addresses are built from the block, group and coefficient counters.
    always_comb begin
        accept  = in_valid & in_ready_q;
        grp_idx = bi_q * ADDR_W'(GPB) + ADDR_W'(g_q);
        y_addr  = grp_idx * ADDR_W'(DCT_DEPTH_Y) + ADDR_W'(k_q);
        c_addr  = grp_idx * ADDR_W'(DCT_DEPTH_C) + ADDR_W'(k_q);
    end

    // Frame sequencing: header, then Y/Cb/Cr per group, then the next block.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        g_d          = g_q;
        blk_d        = blk_q;
        bi_d         = bi_q;
        y_wr_en_d    = 1'b0;
        c_wr_en_d    = 1'b0;
        c_sel_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_done_d = 1'b0;
        hdr_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    blk_d   = '0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    if (32'(in_data) >= 32'(NBLK)) begin
                        hdr_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        bi_d    = ADDR_W'(in_data);
                        g_d     = '0;
                        k_d     = '0;
                        state_d = S_Y;
                    end
                end
            end
            S_Y: begin
                if (accept) begin
                    y_wr_en_d = 1'b1;
                    wr_addr_d = y_addr;
                    wr_data_d = in_data;
                    if (k_q == KW'(DCT_DEPTH_Y - 1)) begin
                        k_d     = '0;
                        state_d = S_CB;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_CB: begin
                if (accept) begin
                    c_wr_en_d = 1'b1;
                    c_sel_d   = 1'b0;
                    wr_addr_d = c_addr;
                    wr_data_d = in_data;
                    if (k_q == KW'(DCT_DEPTH_C - 1)) begin
                        k_d     = '0;
                        state_d = S_CR;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_CR: begin
                if (accept) begin
                    c_wr_en_d = 1'b1;
                    c_sel_d   = 1'b1;
                    wr_addr_d = c_addr;
                    wr_data_d = in_data;
                    if (k_q == KW'(DCT_DEPTH_C - 1)) begin
                        k_d = '0;
                        if (g_q != GW'(GPB - 1)) begin
                            g_d     = g_q + GW'(1);
                            state_d = S_Y;
                        end else begin
                            blk_d = blk_q + BW'(1);
                            if (blk_q == BW'(TOP_BLOCKS_COUNT - 1)) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_HDR;
                            end
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_HDR) || (state_d == S_Y) ||
                     (state_d == S_CB)  || (state_d == S_CR);
        busy_d     = (state_d != S_IDLE);
    end

    // State, counters and registered outputs.
    // Reset also drops any write registered in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            g_q          <= '0;
            blk_q        <= '0;
            bi_q         <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            y_wr_en_q    <= 1'b0;
            c_wr_en_q    <= 1'b0;
            c_sel_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_done_q <= 1'b0;
            hdr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            g_q          <= g_d;
            blk_q        <= blk_d;
            bi_q         <= bi_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            y_wr_en_q    <= y_wr_en_d;
            c_wr_en_q    <= c_wr_en_d;
            c_sel_q      <= c_sel_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_done_q <= frame_done_d;
            hdr_err_q    <= hdr_err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign y_wr_en    = y_wr_en_q;
    assign c_wr_en    = c_wr_en_q;
    assign c_sel      = c_sel_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign hdr_err    = hdr_err_q;

endmodule

// File: tb/tb_jpeg_stream_deserializer.sv
// Bench for jpeg_stream_deserializer.
// A frame model expands block headers into the expected per-word write list.
// A monitor compares every cycle's write outputs against it.
module tb_jpeg_stream_deserializer;

    localparam int GPB = 35;
    localparam int DY  = 5;
    localparam int DC  = 1;

    typedef struct packed {
        logic        wr;
        logic        is_y;
        logic        sel;
        logic [23:0] addr;
        logic [15:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, y_wr_en, c_wr_en, c_sel, frame_done, hdr_err, busy;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;

    jpeg_stream_deserializer dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .y_wr_en(y_wr_en),
        .c_wr_en(c_wr_en), .c_sel(c_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .hdr_err(hdr_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ent_t        exp_q[$];
    logic [15:0] words_q[$];
    ent_t        log_q[$];
    ent_t        log1[$];
    ent_t        pend;
    bit          pend_v = 0;
    bit          mon_en = 0;
    int n_y, n_cb, n_cr, n_done, n_err, stall_cnt, last_wr_cyc, done_cyc;
    int acc_cnt, first_acc, last_acc;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void clr();
        n_y = 0; n_cb = 0; n_cr = 0; n_done = 0; n_err = 0; stall_cnt = 0;
        last_wr_cyc = 0; done_cyc = 0; acc_cnt = 0; first_acc = 0; last_acc = 0;
        log_q.delete();
    endfunction

    // Expand a frame into its stream words and the write each word must produce.
    function automatic void build_frame(input int h0, input int h1, input int h2,
                                        input int h3, input int nblk, input int seed);
        int   h[4];
        int   idx;
        ent_t e;
        h[0] = h0; h[1] = h1; h[2] = h2; h[3] = h3;
        idx = seed;
        exp_q.delete();
        words_q.delete();
        for (int b = 0; b < nblk; b++) begin
            words_q.push_back(16'(h[b]));
            e = '0;
            exp_q.push_back(e);
            if (h[b] >= 4) break;
            for (int g = 0; g < GPB; g++) begin
                for (int k = 0; k < DY; k++) begin
                    e.wr = 1; e.is_y = 1; e.sel = 0;
                    e.addr = 24'((h[b] * GPB + g) * DY + k);
                    e.data = 16'(idx * 37); idx++;
                    words_q.push_back(e.data); exp_q.push_back(e);
                end
                for (int c = 0; c < 2; c++) begin
                    e.wr = 1; e.is_y = 0; e.sel = c[0];
                    e.addr = 24'((h[b] * GPB + g) * DC);
                    e.data = 16'(idx * 37); idx++;
                    words_q.push_back(e.data); exp_q.push_back(e);
                end
            end
        end
    endfunction

    // Per-cycle compare of write outputs against the word accepted one cycle earlier.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("y_wr_en", y_wr_en, pend_v && pend.is_y);
            chk("c_wr_en", c_wr_en, pend_v && !pend.is_y);
            if (pend_v) begin
                chk("wr_addr", wr_addr, pend.addr);
                chk("wr_data", wr_data, pend.data);
                if (!pend.is_y) chk("c_sel", c_sel, pend.sel);
            end
            if (y_wr_en || c_wr_en) begin
                ent_t e;
                e.wr = 1; e.is_y = y_wr_en; e.sel = c_sel; e.addr = wr_addr; e.data = wr_data;
                log_q.push_back(e);
                last_wr_cyc = cyc;
                if (y_wr_en) n_y++;
                else if (c_sel) n_cr++;
                else n_cb++;
            end
            if (frame_done) begin n_done++; done_cyc = cyc; end
            if (hdr_err) n_err++;
            if (in_valid && !in_ready && busy) stall_cnt++;
            if (reset) begin
                pend_v = 0;
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                if (acc_cnt == 0) first_acc = cyc;
                last_acc = cyc;
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious_accept", 1, 0);
                    pend_v = 0;
                end else begin
                    pend = exp_q.pop_front();
                    pend_v = pend.wr;
                end
            end else begin
                pend_v = 0;
            end
        end
    end

    // Drive the prepared words with the given valid duty.
    // Optionally pulse frame_start at word fs_at, or stop after abort_at
    // accepts with in_valid still high.
    task automatic drive(input int duty, input int fs_at, input int abort_at);
        int i = 0;
        int budget = 20000;
        bit fs_done = 0;
        bit v, acc;
        @(posedge clk); #1 frame_start = 1;
        @(posedge clk); #1 frame_start = 0;
        while (i < words_q.size() && budget > 0) begin
            v = (duty >= 100) || ($urandom_range(99) < duty);
            in_valid = v;
            in_data = v ? words_q[i] : 16'($urandom);
            frame_start = (i == fs_at && !fs_done);
            if (i == fs_at) fs_done = 1;
            acc = v && in_ready;
            @(posedge clk); #1;
            frame_start = 0;
            budget--;
            if (acc) begin
                i++;
                if (i == abort_at) begin
                    in_valid = 1;
                    in_data = words_q[i];
                    return;
                end
            end
        end
        if (budget == 0) chk("drive_timeout", 1, 0);
        in_valid = 0;
    endtask

    task automatic wait_done();
        int budget = 50;
        while (n_done == 0 && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        chk("frame_done_seen", n_done, 1);
        chk("in_ready_after_done", in_ready, 0);
        chk("busy_after_done", busy, 0);
        @(negedge clk); #1;
        chk("frame_done_one_cycle", n_done, 1);
    endtask

    initial begin
        int diffs;
        repeat (3) @(posedge clk);
        mon_en = 1;
        #1;
        chk("reset_in_ready", in_ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_wr_addr", wr_addr, 0);
        reset = 0;
        @(posedge clk); #1;

        // Scenario 1: full frame, valid held high.
        clr();
        build_frame(0, 1, 2, 3, 4, 100);
        drive(100, -1, -1);
        wait_done();
        chk("s1_accepts", acc_cnt, 984);
        chk("s1_no_bubbles", last_acc - first_acc + 1, 984);
        chk("s1_y_writes", n_y, 700);
        chk("s1_cb_writes", n_cb, 140);
        chk("s1_cr_writes", n_cr, 140);
        chk("s1_done_latency", done_cyc - last_wr_cyc, 1);
        chk("s1_log_size", log_q.size(), 980);
        if (log_q.size() == 980) begin
            // Scenario 2: header 3 addressing, hand-computed.
            chk("s2_g0_y0_addr", log_q[735].addr, 525);
            chk("s2_g0_y0_isy", log_q[735].is_y, 1);
            chk("s2_g0_cb_addr", log_q[740].addr, 105);
            chk("s2_g0_cb_sel", log_q[740].sel, 0);
            chk("s2_g0_cr_addr", log_q[741].addr, 105);
            chk("s2_g0_cr_sel", log_q[741].sel, 1);
            chk("s2_g34_ylast_addr", log_q[977].addr, 699);
            chk("s2_g34_cr_addr", log_q[979].addr, 139);
            chk("s2_g34_cr_sel", log_q[979].sel, 1);
        end
        log1 = log_q;

        // Scenario 3: ~50% valid gaps, stray frame_start at word 50.
        clr();
        build_frame(0, 1, 2, 3, 4, 100);
        drive(50, 50, -1);
        wait_done();
        chk("s3_accepts", acc_cnt, 984);
        chk("s3_stalls", stall_cnt, 0);
        diffs = 0;
        if (log_q.size() != log1.size()) diffs = 1000;
        else for (int i = 0; i < log_q.size(); i++) if (log_q[i] !== log1[i]) diffs++;
        chk("s3_same_as_s1", diffs, 0);

        // Scenario 4: bad header, then a good frame.
        clr();
        build_frame(4, 0, 0, 0, 1, 0);
        drive(100, -1, -1);
        repeat (5) @(negedge clk);
        #1;
        chk("s4_hdr_err_count", n_err, 1);
        chk("s4_no_writes", n_y + n_cb + n_cr, 0);
        chk("s4_no_done", n_done, 0);
        chk("s4_busy_low", busy, 0);
        clr();
        build_frame(2, 0, 3, 1, 4, 7);
        drive(100, -1, -1);
        wait_done();
        chk("s4_good_writes", n_y + n_cb + n_cr, 980);
        chk("s4_good_no_err", n_err, 0);

        // Scenario 5: reset after 100 words, then a fresh frame.
        clr();
        build_frame(0, 1, 2, 3, 4, 100);
        drive(100, 50, 100);
        chk("s5_accepts_before_reset", acc_cnt, 100);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        in_valid = 0;
        chk("s5_rst_y_wr_en", y_wr_en, 0);
        chk("s5_rst_c_wr_en", c_wr_en, 0);
        chk("s5_rst_c_sel", c_sel, 0);
        chk("s5_rst_wr_addr", wr_addr, 0);
        chk("s5_rst_wr_data", wr_data, 0);
        chk("s5_rst_frame_done", frame_done, 0);
        chk("s5_rst_hdr_err", hdr_err, 0);
        chk("s5_rst_busy", busy, 0);
        chk("s5_rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        clr();
        build_frame(3, 2, 1, 0, 4, 555);
        drive(100, -1, -1);
        wait_done();
        chk("s5_fresh_writes", n_y + n_cb + n_cr, 980);
        chk("s5_fresh_model_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
